// File: rtl/game_flow_pkg.sv
// game_flow_pkg: shared state encoding, screen codes and helpers for the
// game flow controller (TITLE / PLAY / PAUSE / WIN / LOSE).
package game_flow_pkg;

   // State encoding kept as plain constants for compatibility with older code.
   typedef logic [2:0] state_t;

   localparam state_t ST_TITLE = 3'd0;
   localparam state_t ST_PLAY  = 3'd1;
   localparam state_t ST_PAUSE = 3'd2;
   localparam state_t ST_WIN   = 3'd3;
   localparam state_t ST_LOSE  = 3'd4;

   localparam logic [1:0] SCREEN_TITLE = 2'd0;
   localparam logic [1:0] SCREEN_PAUSE = 2'd1;
   localparam logic [1:0] SCREEN_WIN   = 2'd2;
   localparam logic [1:0] SCREEN_LOSE  = 2'd3;

   // Screen to show for a given state; PLAY shows the object mux, so its code is don't-care.
   function automatic logic [1:0] screen_of(input state_t s);
      logic [1:0] scr;
      case (s)
         ST_PAUSE: scr = SCREEN_PAUSE;
         ST_WIN:   scr = SCREEN_WIN;
         ST_LOSE:  scr = SCREEN_LOSE;
         default:  scr = SCREEN_TITLE;
      endcase
      return scr;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/game_flow_ctrl_edge_detect.sv
// edge_detect: rising-edge detector for a debounced key level. The previous
// level is registered; the rise pulse is high for one cycle after a 0->1 change.
module edge_detect (
   input  logic clk,
   input  logic resetN,
   input  logic level,
   output logic rise
);

   logic level_q;

   // Key history, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (!resetN) level_q <= 1'b0;
      else         level_q <= level;
   end

   // Rise while the new level is high and the stored one is low.
   always_comb begin
      rise = level & ~level_q;
   end

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level screen flow FSM. Events are latched into pending
// flags and only acted on at frame start so the screen never changes mid-frame.
// Optional feature: define GAME_FLOW_PAUSE_EN to enable the PAUSE state.
module game_flow_ctrl
   import game_flow_pkg::*;
#(
   parameter int unsigned TITLE_MIN_FRAMES = 60,
   parameter int unsigned END_FRAMES       = 180,
   parameter int unsigned LIVES            = 3
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       start_key,
   input  logic       pause_key,
   input  logic       player_hit,
   input  logic       level_clear,
   output logic       game_on,
   output logic [1:0] screen_sel,
   output logic [1:0] lives,
   output logic       game_reset
);

   localparam int unsigned CntMax = max_u(TITLE_MIN_FRAMES, END_FRAMES);
   localparam int unsigned CW     = (CntMax < 1) ? 1 : $clog2(CntMax + 1);

   logic start_rise, pause_rise;

   state_t        state_q, state_d;
   logic [1:0]    lives_q, lives_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          start_pend_q, start_pend_d;
   logic          hit_pend_q, hit_pend_d;
   logic          clear_pend_q, clear_pend_d;
   logic          pause_pend_q, pause_pend_d;
   logic          start_now, hit_now, clear_now, pause_now;
   logic          reset_pulse_d;

   edge_detect u_start_edge (
      .clk    (clk),
      .resetN (resetN),
      .level  (start_key),
      .rise   (start_rise)
   );

   edge_detect u_pause_edge (
      .clk    (clk),
      .resetN (resetN),
      .level  (pause_key),
      .rise   (pause_rise)
   );

`ifndef GAME_FLOW_PAUSE_EN
   // Pause key has no function in this build.
   logic unused_pause;
   assign unused_pause = pause_rise | pause_pend_q;
`endif

   // Next-state logic: flags accumulate every cycle, decisions happen at frame start.
   always_comb begin
      state_d       = state_q;
      lives_d       = lives_q;
      cnt_d         = cnt_q;
      reset_pulse_d = 1'b0;

      // An event on the frame-start cycle itself still counts for that frame.
      start_now = start_pend_q | start_rise;
      hit_now   = hit_pend_q   | player_hit;
      clear_now = clear_pend_q | level_clear;
`ifdef GAME_FLOW_PAUSE_EN
      pause_now = pause_pend_q | pause_rise;
`else
      pause_now = 1'b0;
`endif

      start_pend_d = start_now;
      hit_pend_d   = hit_now;
      clear_pend_d = clear_now;
      pause_pend_d = pause_now;

      cnt_inc = (cnt_q >= CW'(CntMax)) ? cnt_q : cnt_q + 1'b1;

      if (startOfFrame) begin
         start_pend_d = 1'b0;
         hit_pend_d   = 1'b0;
         clear_pend_d = 1'b0;
         pause_pend_d = 1'b0;
         cnt_d        = cnt_inc;

         case (state_q)
            ST_TITLE: begin
               if (start_now && (cnt_q >= CW'(TITLE_MIN_FRAMES))) begin
                  state_d       = ST_PLAY;
                  lives_d       = 2'(LIVES);
                  reset_pulse_d = 1'b1;
               end
            end
            ST_PLAY: begin
               if (pause_now) begin
                  state_d = ST_PAUSE;
               end else if (hit_now) begin
                  if (lives_q <= 2'd1) begin
                     state_d = ST_LOSE;
                     lives_d = 2'd0;
                  end else begin
                     lives_d       = lives_q - 2'd1;
                     reset_pulse_d = 1'b1;
                  end
               end else if (clear_now) begin
                  state_d = ST_WIN;
               end
            end
`ifdef GAME_FLOW_PAUSE_EN
            ST_PAUSE: begin
               // Time stands still while paused.
               cnt_d = cnt_q;
               if (pause_now) state_d = ST_PLAY;
            end
`endif
            ST_WIN, ST_LOSE: begin
               if ((cnt_inc >= CW'(END_FRAMES)) ||
                   (start_now && (cnt_q >= CW'(END_FRAMES)))) begin
                  state_d = ST_TITLE;
               end
            end
            default: state_d = ST_TITLE;
         endcase

         if (state_d != state_q) cnt_d = '0;
      end
   end

   // State, counters and pending flags.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q      <= ST_TITLE;
         lives_q      <= 2'(LIVES);
         cnt_q        <= '0;
         start_pend_q <= 1'b0;
         hit_pend_q   <= 1'b0;
         clear_pend_q <= 1'b0;
         pause_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lives_q      <= lives_d;
         cnt_q        <= cnt_d;
         start_pend_q <= start_pend_d;
         hit_pend_q   <= hit_pend_d;
         clear_pend_q <= clear_pend_d;
         pause_pend_q <= pause_pend_d;
      end
   end

   // Outputs registered from the next state so game_on and screen_sel move together.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         game_on    <= 1'b0;
         screen_sel <= SCREEN_TITLE;
         game_reset <= 1'b0;
      end else begin
         game_on    <= (state_d == ST_PLAY);
         screen_sel <= screen_of(state_d);
         game_reset <= reset_pulse_d;
      end
   end

   // Lives output mirrors the internal register.
   always_comb begin
      lives = lives_q;
   end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed test of the game flow controller with
// hand-computed expectations (default parameters 60 / 180 / 3).
module tb_game_flow_ctrl;

   logic       clk = 1'b0;
   logic       resetN;
   logic       startOfFrame;
   logic       start_key;
   logic       pause_key;
   logic       player_hit;
   logic       level_clear;
   logic       game_on;
   logic [1:0] screen_sel;
   logic [1:0] lives;
   logic       game_reset;

   int n_checks = 0;
   int n_pass   = 0;

   game_flow_ctrl dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .start_key    (start_key),
      .pause_key    (pause_key),
      .player_hit   (player_hit),
      .level_clear  (level_clear),
      .game_on      (game_on),
      .screen_sel   (screen_sel),
      .lives        (lives),
      .game_reset   (game_reset)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // Advance one clock; sample 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sof(input int n);
      for (int i = 0; i < n; i++) begin
         startOfFrame = 1'b1;
         tick();
         startOfFrame = 1'b0;
         tick();
      end
   endtask

   task automatic press_start();
      start_key = 1'b1;
      tick();
      start_key = 1'b0;
      tick();
   endtask

   task automatic press_pause();
      pause_key = 1'b1;
      tick();
      pause_key = 1'b0;
      tick();
   endtask

   task automatic hit();
      player_hit = 1'b1;
      tick();
      player_hit = 1'b0;
      tick();
   endtask

   task automatic clear();
      level_clear = 1'b1;
      tick();
      level_clear = 1'b0;
      tick();
   endtask

   initial begin
      resetN       = 1'b0;
      startOfFrame = 1'b0;
      start_key    = 1'b0;
      pause_key    = 1'b0;
      player_hit   = 1'b0;
      level_clear  = 1'b0;
      tick();
      tick();
      check("rst_game_on", 32'(game_on), 0);
      check("rst_screen", 32'(screen_sel), 0);
      check("rst_lives", 32'(lives), 3);
      check("rst_game_reset", 32'(game_reset), 0);
      resetN = 1'b1;
      tick();

      // Early start at frame 10 is discarded.
      sof(10);
      press_start();
      sof(1);
      check("early_start_ignored", 32'(game_on), 0);
      check("early_start_no_reset", 32'(game_reset), 0);

      // Counter now 11; 50 more frames -> 61, start accepted at next frame.
      sof(50);
      press_start();
      check("start_waits_frame", 32'(game_on), 0);
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      check("play_game_on", 32'(game_on), 1);
      check("play_lives", 32'(lives), 3);
      check("play_reset_pulse", 32'(game_reset), 1);
      tick();
      check("play_reset_once", 32'(game_reset), 0);

      // First hit: lives 2, board reset, stay in PLAY.
      hit();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      check("hit1_lives", 32'(lives), 2);
      check("hit1_game_on", 32'(game_on), 1);
      check("hit1_reset", 32'(game_reset), 1);
      tick();

      // Hit and clear in one frame: hit wins, no WIN.
      hit();
      clear();
      sof(1);
      check("hitclr_lives", 32'(lives), 1);
      check("hitclr_game_on", 32'(game_on), 1);
      check("hitclr_screen", 32'(screen_sel), 0);

      // Fatal hit.
      hit();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      check("lose_game_on", 32'(game_on), 0);
      check("lose_screen", 32'(screen_sel), 3);
      check("lose_lives", 32'(lives), 0);
      check("lose_no_reset", 32'(game_reset), 0);
      tick();

      // LOSE held for 180 frames.
      sof(179);
      check("lose_held_179", 32'(screen_sel), 3);
      sof(1);
      check("lose_to_title", 32'(screen_sel), 0);
      check("title_game_on", 32'(game_on), 0);

      // New game after 60 title frames.
      sof(60);
      press_start();
      sof(1);
      check("game2_game_on", 32'(game_on), 1);
      check("game2_lives", 32'(lives), 3);

      // Pause behaviour depends on the build.
      press_pause();
      sof(1);
`ifdef GAME_FLOW_PAUSE_EN
      check("pause_screen", 32'(screen_sel), 1);
      check("pause_game_on", 32'(game_on), 0);
      hit();
      sof(1);
      check("pause_hit_ignored", 32'(lives), 3);
      check("pause_still", 32'(screen_sel), 1);
      press_pause();
      sof(1);
      check("unpause_game_on", 32'(game_on), 1);
      check("unpause_lives", 32'(lives), 3);
`else
      check("nopause_game_on", 32'(game_on), 1);
      check("nopause_screen", 32'(screen_sel), 0);
      check("nopause_lives", 32'(lives), 3);
`endif

      // Mid-frame clear: picture unchanged until frame start.
      clear();
      tick();
      tick();
      check("clear_midframe", 32'(game_on), 1);
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      check("win_game_on", 32'(game_on), 0);
      check("win_screen", 32'(screen_sel), 2);
      tick();

      // Hit in WIN has no effect.
      hit();
      sof(1);
      check("win_hit_ignored", 32'(lives), 3);
      check("win_stays", 32'(screen_sel), 2);

      // Reset during WIN.
      resetN = 1'b0;
      tick();
      check("rst_win_screen", 32'(screen_sel), 0);
      check("rst_win_game_on", 32'(game_on), 0);
      check("rst_win_lives", 32'(lives), 3);
      check("rst_win_game_reset", 32'(game_reset), 0);
      resetN = 1'b1;
      tick();
      check("post_rst_game_reset", 32'(game_reset), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter TITLE_MIN_FRAMES, default 60: frames the title screen is held before start_key is accepted.
REQ-002 Parameter END_FRAMES, default 180: frames the WIN/LOSE screen is held before automatic return to TITLE.
REQ-003 Parameter LIVES, default 3: lives loaded at each new game; legal range 1..3.
REQ-004 Port clk  input  1  system clock.
REQ-005 Port resetN  input  1  reset, synchronous, active-low.
REQ-006 Port startOfFrame  input  1  one-cycle pulse at each VGA frame start.
REQ-007 Port start_key  input  1  debounced level; a rising edge is a start request.
REQ-008 Port pause_key  input  1  debounced level; a rising edge is a pause-toggle request.
REQ-009 Port player_hit  input  1  one-cycle pulse; player killed.
REQ-010 Port level_clear  input  1  one-cycle pulse; all targets destroyed.
REQ-011 Port game_on  output  1  1 = drive the object-mux picture; 0 = drive the game-screen picture.
REQ-012 Port screen_sel  output  2  screen to render: 0 TITLE, 1 PAUSE, 2 WIN, 3 LOSE.
REQ-013 Port lives  output  2  lives remaining.
REQ-014 Port game_reset  output  1  one-cycle pulse that re-initialises the board objects.

Function
REQ-015 The FSM SHALL have five states: TITLE, PLAY, PAUSE, WIN, LOSE.
REQ-016 Key rising edges, player_hit and level_clear SHALL be captured into sticky pending flags on the cycle they occur.
REQ-017 State transitions SHALL occur only on a cycle with startOfFrame=1, so the screen never changes mid-frame; all pending flags SHALL clear on that same cycle.
REQ-018 A frame counter SHALL increment on each startOfFrame, saturate at max(TITLE_MIN_FRAMES, END_FRAMES), and clear on every state change.
REQ-019 TITLE->PLAY SHALL occur on a pending start with frame count >= TITLE_MIN_FRAMES; earlier starts are discarded.
REQ-020 On TITLE->PLAY, lives SHALL load LIVES and game_reset SHALL pulse high for exactly the transition cycle.
REQ-021 In PLAY, a pending hit SHALL decrement lives; if lives==1, the state SHALL go to LOSE with lives=0.
REQ-022 In PLAY, a pending clear with no pending hit SHALL go to WIN; hit has priority when both are pending in one frame.
REQ-023 In PLAY, after a non-fatal hit, game_reset SHALL pulse once and the state SHALL stay PLAY.
REQ-024 WIN or LOSE SHALL go to TITLE when frame count reaches END_FRAMES; a pending start at count >= END_FRAMES also returns to TITLE.
REQ-025 game_on SHALL be 1 only in PLAY; screen_sel SHALL be registered and decoded from the next state, so it changes together with game_on.
REQ-026 Events arriving in states that ignore them SHALL have no effect beyond flag clearing.

Reset
REQ-027 While resetN=0 at a clk edge: state TITLE, game_on 0, screen_sel 0, lives LIVES, game_reset 0, counter 0, pending flags 0, key edge history 0.
REQ-028 Reset asserted mid-game SHALL return to TITLE on the next edge with no game_reset pulse.

Configuration
REQ-029 With macro GAME_FLOW_PAUSE_EN defined, a pending pause SHALL toggle PLAY<->PAUSE at frame start; PAUSE freezes lives and the counter, and ignores hit/clear.
REQ-030 Without GAME_FLOW_PAUSE_EN, the PAUSE state SHALL not exist, pause_key SHALL be ignored, and screen_sel SHALL never equal 1.

Structure
REQ-031 Package game_flow_pkg SHALL hold the state enum and the SCREEN_TITLE/PAUSE/WIN/LOSE 2-bit constants.
REQ-032 Sub-module edge_detect (registered rising-edge detector, synchronous active-low resetN) SHALL be instantiated once per key.

Verification
REQ-033 Reset, start at frame 10 then at frame 61 -> first ignored; at the next startOfFrame game_on=1, lives=3, one game_reset pulse.
REQ-034 In PLAY, inject 3 player_hit in separate frames -> lives 2, 1, then LOSE with screen_sel=3, game_on=0; TITLE after 180 frames.
REQ-035 player_hit and level_clear in the same frame with lives=2 -> lives=1, state PLAY, no WIN.
REQ-036 level_clear mid-frame -> game_on stays 1 until the next startOfFrame, then 0 with screen_sel=2.
REQ-037 GAME_FLOW_PAUSE_EN: pause edge -> screen_sel=1, hit ignored; second edge -> PLAY, lives unchanged; without the macro, the pause edge has no effect.
REQ-038 resetN low during WIN -> next cycle TITLE, lives=3, game_reset=0.
